// File: rtl/blink_sequencer.sv
// blink_sequencer: steps through a small table of LED patterns. Each entry
// blinks its pattern (ON phase, then dark OFF phase) reps+1 times before the
// sequence advances. The sequence either wraps or stops after the last entry.
// Blink speed, pause and restart are controlled at run time, and the table
// can be rewritten at any time.
module blink_sequencer #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BLINK_DIV = 4,
    parameter int LED_W     = 8,
    parameter int NUM_STEPS = 5,
    localparam int AW       = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             loop,
    input  logic [1:0]       speed,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LED_W-1:0] wr_pattern,
    input  logic [2:0]       wr_reps,
    output logic [LED_W-1:0] leds,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    step_idx
);

    // Base half-period in clock cycles, and a counter wide enough to hold it.
    localparam int H0 = CLK_FREQ / BLINK_DIV;
    localparam int CW = $clog2(H0 + 1);

    localparam logic [CW-1:0] H0_C        = CW'(H0);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO_C  = CW'(0);
    localparam logic [AW-1:0] STEP_ONE_C  = AW'(1);
    localparam logic [AW-1:0] STEP_ZERO_C = AW'(0);
    localparam logic [AW-1:0] LAST_STEP_C = AW'(NUM_STEPS - 1);
    localparam logic [31:0]   NUM_STEPS_C = 32'(NUM_STEPS);
    localparam logic [LED_W-1:0] LEDS_OFF_C = {LED_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // Power-on pattern for entry idx: low idx+1 bits lit, saturating at all-ones.
    function automatic logic [LED_W-1:0] init_pattern(input int idx);
        logic [LED_W-1:0] p;
        p = {LED_W{1'b0}};
        for (int b = 0; b < LED_W; b++) begin
            p[b] = (b <= idx);
        end
        return p;
    endfunction

    // Power-on repeat count for entry idx: idx mod 8.
    function automatic logic [2:0] init_reps(input int idx);
        return 3'(idx % 8);
    endfunction

    // Pattern table
    logic [LED_W-1:0] pat_r  [NUM_STEPS];
    logic [2:0]       reps_r [NUM_STEPS];

    // Sequencer registers
    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [2:0]       blink_r;
    logic [AW-1:0]    step_r;
    logic [LED_W-1:0] leds_r;
    logic             busy_r;
    logic             done_r;

    // Next-state values
    state_t           state_s;
    logic [CW-1:0]    cnt_s;
    logic [2:0]       blink_s;
    logic [AW-1:0]    step_s;
    logic [LED_W-1:0] leds_s;
    logic             done_s;
    logic             busy_s;

    // Helpers
    logic [CW-1:0]    term_s;
    logic             phase_end_s;
    logic [AW-1:0]    step_inc_s;
    logic             wr_ok_s;

    // Terminal count follows speed combinationally, so a speed change acts
    // mid-phase; a counter already past the new terminal ends the phase at once.
    assign term_s      = (H0_C >> speed) - CNT_ONE_C;
    assign phase_end_s = (cnt_r >= term_s);
    assign step_inc_s  = step_r + STEP_ONE_C;
    assign wr_ok_s     = (32'(wr_addr) < NUM_STEPS_C);
    assign busy_s      = (state_s != ST_IDLE);

    // Table storage: reload defaults on reset, otherwise accept in-range writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pat_r[i]  <= init_pattern(i);
                reps_r[i] <= init_reps(i);
            end
        end else if (wr_en && wr_ok_s) begin
            pat_r[wr_addr]  <= wr_pattern;
            reps_r[wr_addr] <= wr_reps;
        end
    end

    // Next-state and next-output logic; start overrides pause and completion.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        blink_s = blink_r;
        step_s  = step_r;
        leds_s  = leds_r;
        done_s  = 1'b0;

        if (start) begin
            state_s = ST_ON;
            cnt_s   = CNT_ZERO_C;
            blink_s = 3'd0;
            step_s  = STEP_ZERO_C;
            leds_s  = pat_r[0];
        end else begin
            case (state_r)
                ST_IDLE: begin
                    leds_s = LEDS_OFF_C;
                end
                ST_ON: begin
                    if (pause) begin
                        cnt_s = cnt_r;
                    end else if (phase_end_s) begin
                        cnt_s   = CNT_ZERO_C;
                        state_s = ST_OFF;
                        leds_s  = LEDS_OFF_C;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE_C;
                    end
                end
                ST_OFF: begin
                    if (pause) begin
                        cnt_s = cnt_r;
                    end else if (phase_end_s) begin
                        cnt_s = CNT_ZERO_C;
                        if (blink_r < reps_r[step_r]) begin
                            // Another blink of the same entry
                            blink_s = blink_r + 3'd1;
                            state_s = ST_ON;
                            leds_s  = pat_r[step_r];
                        end else begin
                            blink_s = 3'd0;
                            if (step_r == LAST_STEP_C) begin
                                step_s = STEP_ZERO_C;
                                if (loop) begin
                                    state_s = ST_ON;
                                    leds_s  = pat_r[0];
                                end else begin
                                    state_s = ST_IDLE;
                                    leds_s  = LEDS_OFF_C;
                                    done_s  = 1'b1;
                                end
                            end else begin
                                step_s  = step_inc_s;
                                state_s = ST_ON;
                                leds_s  = pat_r[step_inc_s];
                            end
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE_C;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO_C;
                    blink_s = 3'd0;
                    step_s  = STEP_ZERO_C;
                    leds_s  = LEDS_OFF_C;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO_C;
            blink_r <= 3'd0;
            step_r  <= STEP_ZERO_C;
            leds_r  <= LEDS_OFF_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            blink_r <= blink_s;
            step_r  <= step_s;
            leds_r  <= leds_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign leds     = leds_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign step_idx = step_r;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed testbench for blink_sequencer with H0 = 8 cycles, 8 LEDs, 5 steps.
module tb_blink_sequencer;

    localparam int LED_W     = 8;
    localparam int NUM_STEPS = 5;
    localparam int AW        = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             pause;
    logic             loop;
    logic [1:0]       speed;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [LED_W-1:0] wr_pattern;
    logic [2:0]       wr_reps;
    logic [LED_W-1:0] leds;
    logic             busy;
    logic             done;
    logic [AW-1:0]    step_idx;

    int n_cmp = 0;
    int n_err = 0;

    // Default table contents and reps
    logic [7:0] def_pat [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    int         def_rep [5] = '{0, 1, 2, 3, 4};

    blink_sequencer #(
        .CLK_FREQ (32),
        .BLINK_DIV(4),
        .LED_W    (LED_W),
        .NUM_STEPS(NUM_STEPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .loop      (loop),
        .speed     (speed),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_pattern(wr_pattern),
        .wr_reps   (wr_reps),
        .leds      (leds),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; pause = 1'b0; loop = 1'b0; speed = 2'd0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_pattern = 8'hFF; wr_reps = 3'd7;
        tick; tick;
        n_cmp++;
        if (leds !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state got leds=%h busy=%b done=%b step=%0d, want 00/0/0/0",
                     leds, busy, done, step_idx);
        end
        rst_n = 1'b1; start = 1'b0; wr_en = 1'b0;
        tick;
        n_cmp++;
        if (busy !== 1'b0 || leds !== 8'h00) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b leds=%h, want 0/00", busy, leds);
        end
    endtask

    task automatic test_oneshot;
        logic [7:0] exp_l;
        loop = 1'b0; speed = 2'd0;
        start = 1'b1; tick; start = 1'b0;
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b <= def_rep[s]; b++) begin
                for (int c = 0; c < 16; c++) begin
                    exp_l = (c < 8) ? def_pat[s] : 8'h00;
                    n_cmp++;
                    if (leds !== exp_l) begin
                        n_err++;
                        $display("FAIL oneshot_leds s=%0d b=%0d c=%0d got %h want %h", s, b, c, leds, exp_l);
                    end
                    n_cmp++;
                    if (step_idx !== 3'(s) || busy !== 1'b1 || done !== 1'b0) begin
                        n_err++;
                        $display("FAIL oneshot_ctl s=%0d c=%0d got step=%0d busy=%b done=%b, want %0d/1/0",
                                 s, c, step_idx, busy, done, s);
                    end
                    tick;
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || step_idx !== 3'd0 || leds !== 8'h00) begin
            n_err++;
            $display("FAIL oneshot_end got busy=%b done=%b step=%0d leds=%h, want 0/1/0/00",
                     busy, done, step_idx, leds);
        end
        tick;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_done_pulse got done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_loop_speed;
        logic [7:0] exp_l;
        int k;
        loop = 1'b1; speed = 2'd2;
        start = 1'b1; tick; start = 1'b0;
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b <= def_rep[s]; b++) begin
                for (int c = 0; c < 4; c++) begin
                    exp_l = (c < 2) ? def_pat[s] : 8'h00;
                    n_cmp++;
                    if (leds !== exp_l || step_idx !== 3'(s)) begin
                        n_err++;
                        $display("FAIL loop_seq s=%0d b=%0d c=%0d got leds=%h step=%0d want %h/%0d",
                                 s, b, c, leds, step_idx, exp_l, s);
                    end
                    tick;
                end
            end
        end
        n_cmp++;
        if (step_idx !== 3'd0 || leds !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL loop_wrap got step=%0d leds=%h busy=%b done=%b, want 0/01/1/0",
                     step_idx, leds, busy, done);
        end
        loop = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            tick;
            k++;
        end
        n_cmp++;
        if (k !== 60 || done !== 1'b1) begin
            n_err++;
            $display("FAIL loop_stop got cycles=%0d done=%b, want 60/1", k, done);
        end
    endtask

    task automatic test_pause;
        int on_cnt;
        bit stop;
        loop = 1'b0; speed = 2'd0;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++;
            if (leds !== 8'h01 || busy !== 1'b1 || step_idx !== 3'd0) begin
                n_err++;
                $display("FAIL pause_hold i=%0d got leds=%h busy=%b step=%0d, want 01/1/0",
                         i, leds, busy, step_idx);
            end
        end
        pause = 1'b0;
        on_cnt = 8;
        stop = 1'b0;
        while (!stop && on_cnt < 40) begin
            tick;
            if (leds === 8'h01) on_cnt++;
            else stop = 1'b1;
        end
        n_cmp++;
        if (on_cnt !== 13) begin
            n_err++;
            $display("FAIL pause_on_len got %0d cycles, want 13", on_cnt);
        end
        n_cmp++;
        if (leds !== 8'h00 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pause_off got leds=%h busy=%b, want 00/1", leds, busy);
        end
    endtask

    task automatic test_restart;
        int k;
        loop = 1'b1; speed = 2'd0;
        start = 1'b1; tick; start = 1'b0;
        k = 0;
        while (!(step_idx === 3'd3 && leds === 8'h00 && busy === 1'b1) && k < 400) begin
            tick;
            k++;
        end
        n_cmp++;
        if (step_idx !== 3'd3 || leds !== 8'h00) begin
            n_err++;
            $display("FAIL restart_reach_step3_off got step=%0d leds=%h after %0d cycles", step_idx, leds, k);
        end
        start = 1'b1; tick; start = 1'b0;
        n_cmp++;
        if (step_idx !== 3'd0 || leds !== 8'h01 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart got step=%0d leds=%h busy=%b, want 0/01/1", step_idx, leds, busy);
        end
    endtask

    task automatic test_write;
        logic [7:0] wpat [5];
        int         wrep [5];
        logic [7:0] exp_l;
        int k;
        wpat = '{8'hA5, 8'h03, 8'h07, 8'h0F, 8'h1F};
        wrep = '{1, 1, 2, 3, 4};
        loop = 1'b1; speed = 2'd2;
        start = 1'b1; tick; start = 1'b0;
        k = 0;
        while (step_idx !== 3'd2 && k < 100) begin
            tick;
            k++;
        end
        n_cmp++;
        if (step_idx !== 3'd2) begin
            n_err++;
            $display("FAIL write_reach_step2 got step=%0d", step_idx);
        end
        wr_en = 1'b1; wr_addr = 3'd0; wr_pattern = 8'hA5; wr_reps = 3'd1;
        tick;
        wr_addr = 3'd7; wr_pattern = 8'hFF; wr_reps = 3'd7;
        tick;
        wr_en = 1'b0;
        k = 0;
        while (step_idx !== 3'd0 && k < 200) begin
            tick;
            k++;
        end
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b <= wrep[s]; b++) begin
                for (int c = 0; c < 4; c++) begin
                    exp_l = (c < 2) ? wpat[s] : 8'h00;
                    n_cmp++;
                    if (leds !== exp_l || step_idx !== 3'(s)) begin
                        n_err++;
                        $display("FAIL write_seq s=%0d b=%0d c=%0d got leds=%h step=%0d want %h/%0d",
                                 s, b, c, leds, step_idx, exp_l, s);
                    end
                    tick;
                end
            end
        end
        n_cmp++;
        if (step_idx !== 3'd0 || leds !== 8'hA5) begin
            n_err++;
            $display("FAIL write_second_wrap got step=%0d leds=%h, want 0/A5", step_idx, leds);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_l;
        tick;
        rst_n = 1'b0;
        tick;
        n_cmp++;
        if (leds !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid got leds=%h busy=%b done=%b step=%0d, want 00/0/0/0",
                     leds, busy, done, step_idx);
        end
        rst_n = 1'b1; loop = 1'b0; speed = 2'd0;
        tick;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_idle got busy=%b, want 0", busy);
        end
        start = 1'b1; tick; start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            exp_l = (c < 8) ? 8'h01 : 8'h00;
            n_cmp++;
            if (leds !== exp_l || step_idx !== 3'd0) begin
                n_err++;
                $display("FAIL reset_table_step0 c=%0d got leds=%h step=%0d want %h/0", c, leds, step_idx, exp_l);
            end
            tick;
        end
        n_cmp++;
        if (step_idx !== 3'd1 || leds !== 8'h03) begin
            n_err++;
            $display("FAIL reset_table_step1 got step=%0d leds=%h, want 1/03", step_idx, leds);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; loop = 1'b0; speed = 2'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_pattern = 8'h00; wr_reps = 3'd0;
        test_reset;
        test_oneshot;
        test_loop_speed;
        test_pause;
        test_restart;
        test_write;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
